// File: rtl/dbus_bridge.sv
// Data-side bus bridge: decodes one CPU load/store to the RAM or MMIO slave and stalls until the ack.
// Optional bus-error timeout is compiled in with `define DBUS_TIMEOUT_EN.
module dbus_bridge #(
  parameter logic [31:0] MMIO_BASE      = 32'h1FAF_0000,
  parameter logic [31:0] MMIO_MASK      = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_paddr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        ram_req,
  output logic        ram_wr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        io_req,
  output logic        io_wr,
  output logic [3:0]  io_be,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mmio_hit;
  logic [31:0] word_addr;

  assign mmio_hit  = (cpu_paddr & MMIO_MASK) == MMIO_BASE;
  assign word_addr = {cpu_paddr[31:2], 2'b00};

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  // wait_cnt counts completed WAIT cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      ram_req   <= 1'b0;
      ram_wr    <= 1'b0;
      ram_be    <= 4'h0;
      ram_addr  <= 32'h0;
      ram_wdata <= 32'h0;
      io_req    <= 1'b0;
      io_wr     <= 1'b0;
      io_be     <= 4'h0;
      io_addr   <= 32'h0;
      io_wdata  <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (cpu_req) begin
`ifdef DBUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (mmio_hit) begin
              io_req   <= 1'b1;
              io_wr    <= cpu_wr;
              io_be    <= cpu_be;
              io_addr  <= word_addr;
              io_wdata <= cpu_wdata;
              state    <= IO_WAIT;
            end else begin
              ram_req   <= 1'b1;
              ram_wr    <= cpu_wr;
              ram_be    <= cpu_be;
              ram_addr  <= word_addr;
              ram_wdata <= cpu_wdata;
              state     <= RAM_WAIT;
            end
          end
        end

        RAM_WAIT: begin
          if (ram_ack) begin
            rdata_q   <= ram_wr ? 32'h0 : ram_rdata;
            err_q     <= 1'b0;
            ram_req   <= 1'b0;
            ram_wr    <= 1'b0;
            ram_be    <= 4'h0;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
            state     <= DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (wait_expired) begin
            rdata_q   <= 32'h0;
            err_q     <= 1'b1;
            ram_req   <= 1'b0;
            ram_wr    <= 1'b0;
            ram_be    <= 4'h0;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        IO_WAIT: begin
          if (io_ack) begin
            rdata_q  <= io_wr ? 32'h0 : io_rdata;
            err_q    <= 1'b0;
            io_req   <= 1'b0;
            io_wr    <= 1'b0;
            io_be    <= 4'h0;
            io_addr  <= 32'h0;
            io_wdata <= 32'h0;
            state    <= DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (wait_expired) begin
            rdata_q  <= 32'h0;
            err_q    <= 1'b1;
            io_req   <= 1'b0;
            io_wr    <= 1'b0;
            io_be    <= 4'h0;
            io_addr  <= 32'h0;
            io_wdata <= 32'h0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        DONE: begin
          // single release cycle; cpu_req is deliberately not looked at here
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == RAM_WAIT) || (state == IO_WAIT);

`ifdef DBUS_TIMEOUT_EN
  assign cpu_err = err_q & (state == DONE);
`else
  logic unused_err;
  assign unused_err = err_q;
  assign cpu_err    = 1'b0;
`endif

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-side bus bridge downstream of the kseg address mapper. It takes one CPU load/store per transaction on the mapped physical address and decodes it to either the RAM port or the MMIO (confreg) port. It runs a level request / pulse-ack handshake with the selected slave and stalls the CPU until the response returns. It sits between the MEM stage and the SoC data slaves.

## Interface
- `MMIO_BASE`, default 32'h1FAF_0000: physical base of the MMIO window.
- `MMIO_MASK`, default 32'hFFFF_0000: an address is MMIO when `(cpu_paddr & MMIO_MASK) == MMIO_BASE`.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `*_req` is held; used only with `DBUS_TIMEOUT_EN`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: MEM stage requests an access.
- `cpu_wr` in 1: 1 = store, 0 = load.
- `cpu_be` in 4: byte enables.
- `cpu_paddr` in 32: physical address, already mapped.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data, valid in DONE.
- `cpu_stall` out 1: freezes the pipeline.
- `cpu_err` out 1: bus error flag, valid in DONE.
- `ram_req`, `ram_wr` out 1; `ram_be` out 4; `ram_addr`, `ram_wdata` out 32: RAM slave request.
- `ram_rdata` in 32; `ram_ack` in 1: RAM slave response.
- `io_req`, `io_wr` out 1; `io_be` out 4; `io_addr`, `io_wdata` out 32: MMIO slave request.
- `io_rdata` in 32; `io_ack` in 1: MMIO slave response.

## Operation
- States: IDLE, RAM_WAIT, IO_WAIT, DONE.
- IDLE:
  - When `cpu_req`=1, latch `cpu_wr`, `cpu_be`, `cpu_paddr`, `cpu_wdata`.
  - Go to IO_WAIT on an MMIO hit, else RAM_WAIT.
- Slave addresses are word-aligned: `{paddr[31:2],2'b00}`. Byte lanes are carried by `*_be`.
- RAM_WAIT / IO_WAIT:
  - The selected `*_req`=1 with the latched fields; the other slave's `*_req`=0.
  - `*_req` holds until that slave's `*_ack`=1.
  - On ack, latch `*_rdata`; for stores the latched value is 32'h0. Go to DONE.
- DONE:
  - `cpu_stall`=0 and `cpu_rdata` = latched data for exactly one cycle, then IDLE.
  - `cpu_req` is not sampled in DONE.
- `cpu_stall` is combinational: 1 in IDLE while `cpu_req`=1, 1 in both WAIT states, 0 in DONE, 0 in IDLE with no request.
- Ignored acks:
  - Any `*_ack` in IDLE or DONE.
  - The ack of the non-selected slave.
- Non-selected slave outputs (`*_addr`, `*_wdata`, `*_be`, `*_wr`) are 0.

## Timing
- Reset values:
  - State IDLE.
  - All `*_req`, `*_wr` = 0; all `*_be` = 0; `*_addr`, `*_wdata` = 0.
  - `cpu_rdata` = 0, `cpu_err` = 0, `cpu_stall` = `cpu_req`.
- Latency:
  - Accept at cycle 0; `*_req` high from cycle 1.
  - Ack at cycle N (N ≥ 1) gives DONE at N+1.
  - Minimum 3 cycles per access; stall high for cycles 0..N.
- An ack in the first cycle `*_req` is high is legal.
- Back-to-back: a request presented the cycle after DONE is accepted in IDLE; no bubble beyond DONE.
- Reset mid-transaction: `*_req` drops asynchronously, the state returns to IDLE, and a late ack after reset is ignored.

## Configuration
- `DBUS_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to a WAIT state and increments each WAIT cycle.
  - If `*_req` has been high `TIMEOUT_CYCLES` cycles with no ack, drop `*_req` and go to DONE with `cpu_rdata`=32'h0 and `cpu_err`=1 for that DONE cycle.
  - An ack in the final allowed cycle wins: normal completion, `cpu_err`=0.
- `DBUS_TIMEOUT_EN` undefined:
  - The bridge waits indefinitely.
  - `cpu_err` is tied to 0; `TIMEOUT_CYCLES` is unused.

## Test plan
- Load `cpu_paddr`=32'h0000_1004, `ram_ack` on the first req cycle with `ram_rdata`=32'hDEAD_BEEF → `ram_addr`=32'h0000_1004, `io_req`=0, DONE at cycle 2 with `cpu_rdata`=32'hDEAD_BEEF, stall high for cycles 0-1.
- Store `cpu_paddr`=32'h1FAF_F002, `be`=4'b0100, `wdata`=32'h00AB_0000, `io_ack` after 4 cycles → `io_addr`=32'h1FAF_F000, `io_wr`=1, `io_be`=4'b0100, `ram_req` never high.
- Spurious `ram_ack` pulses in IDLE and during IO_WAIT → no state change; the transaction completes only on `io_ack`.
- Assert `rst_n`=0 during RAM_WAIT, release, then pulse `ram_ack` → `ram_req` falls asynchronously, state stays IDLE, `cpu_rdata` stays 0.
- With `DBUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no ack → `ram_req` high exactly 8 cycles, then DONE with `cpu_err`=1, `cpu_rdata`=0.
- Repeat the previous case with ack in the 8th cycle → `cpu_err`=0 and the returned data is delivered.
